// File: rtl/div_pkg.sv
// Shared constants for the sequential restoring divider: default width,
// counter width and the FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_FIX  = 3'd2,
    S_ZERO = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_restoring_step.sv
// One restoring division step: shift {rem, quo} left, trial-subtract the divisor,
// keep the difference and set the quotient bit only when it does not go negative.
module div_restoring_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0]   shifted;
  logic [W+1:0] trial;
  logic         trial_neg;

  assign shifted = {rem_i, quo_i[W-1]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
  // A non-negative trial is always below 2^W, so any set upper bit means a borrow.
  assign trial_neg = |trial[W+1:W];

  assign rem_o = trial_neg ? shifted[W-1:0] : trial[W-1:0];
  assign quo_o = {quo_i[W-2:0], ~trial_neg};

endmodule

// File: rtl/seq_divider_32bit.sv
// Multi-cycle div/divu: quotient on Low, remainder on High, Done pulse after edge WIDTH+1
// (edge 2 on divide-by-zero); Start is ignored while Busy.
module seq_divider_32bit
  import div_pkg::*;
#(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low,
  output logic             DivByZero
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             neg_quo_q, neg_rem_q;
  logic             busy_q, done_q, dbz_q;
  logic [WIDTH-1:0] high_q, low_q;

  logic [WIDTH-1:0] rem_d, quo_d;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             b_zero;

  assign abs_a  = (Signed && A[WIDTH-1]) ? -A : A;
  assign abs_b  = (Signed && B[WIDTH-1]) ? -B : B;
  assign b_zero = (B == '0);

  div_restoring_step #(.W(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      high_q    <= '0;
      low_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
            dvsr_q    <= abs_b;
            // The zero path reports the raw dividend, so park it in the quotient register.
            quo_q     <= b_zero ? A : abs_a;
            neg_quo_q <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            neg_rem_q <= Signed & A[WIDTH-1];
            state_q   <= b_zero ? S_ZERO : S_RUN;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          low_q   <= neg_quo_q ? -quo_q : quo_q;
          high_q  <= neg_rem_q ? -rem_q : rem_q;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_ZERO: begin
          // Two cycles here so Done lands after edge 2 of the request.
          if (cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else begin
            cnt_q   <= '0;
            low_q   <= '1;
            high_q  <= quo_q;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign High      = high_q;
  assign Low       = low_q;
  assign DivByZero = dbz_q;

endmodule
